// File: rtl/ieee_pkg.sv
// ieee_pkg: shared constants and helpers for the drive ROM arbiter
package ieee_pkg;
  localparam int IEEE_MAX_DRV = 4;
  typedef logic [3:0] rd_lat_t;
  localparam rd_lat_t IEEE_RD_LAT = 4'd3;
  function automatic int ieee_cnt_w(input int ndr, input int rdlat);
    return $clog2(ndr + rdlat + 1);
  endfunction
endpackage

// File: rtl/ieee_slot_counter.sv
// ieee_slot_counter: ph2-restarted saturating slot counter with sticky overrun
module ieee_slot_counter #(
  parameter int IDLE = 7,
  parameter int CW = 3
)(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ph2_i,
  output logic [CW-1:0] cnt_o,
  output logic          overrun_o
);
  localparam logic [CW-1:0] IDLE_C = CW'(IDLE);
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovr_q, ovr_d;
  // ph2 restarts the frame; otherwise advance and park at IDLE; ph2 mid-frame is an overrun
  always_comb begin
    cnt_d = ph2_i ? '0 : (cnt_q == IDLE_C ? cnt_q : cnt_q + CW'(1));
    ovr_d = ovr_q | (ph2_i & (cnt_q < IDLE_C));
  end
  // state registers, reset parks the counter at IDLE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= IDLE_C;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end
  assign cnt_o = cnt_q;
  assign overrun_o = ovr_q;
endmodule

// File: rtl/ieee_rom_arbiter.sv
// ieee_rom_arbiter: slots one shared ROM/RAM port between drive reads and loader writes
module ieee_rom_arbiter import ieee_pkg::*; #(
  parameter int      NDR = 4,
  parameter int      ADDRWIDTH = 14,
  parameter rd_lat_t RDLAT = IEEE_RD_LAT
)(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ph2,
  input  logic [NDR-1:0]                drv_en,
  input  logic [NDR-1:0][ADDRWIDTH-1:0] drv_addr,
  output logic [NDR-1:0][7:0]           drv_data,
  input  logic                          ld_excl,
  input  logic                          ld_req,
  input  logic [ADDRWIDTH-1:0]          ld_addr,
  input  logic [7:0]                    ld_data,
  output logic                          ld_ack,
  output logic [ADDRWIDTH-1:0]          rom_addr,
  output logic [7:0]                    rom_data,
  output logic                          rom_we,
  input  logic [7:0]                    rom_q,
  output logic                          overrun
);
  localparam int IDLE = NDR + int'(RDLAT);
  localparam int CW = ieee_cnt_w(NDR, int'(RDLAT));
  logic [CW-1:0] cnt;
  logic [NDR-1:0] rd_sel, cap, pend_q, pend_d;
  logic [ADDRWIDTH-1:0] rd_addr, addr_q;
  logic [7:0] data_q;
  logic we_q, ack_q, rd_slot, wr;
  logic [NDR-1:0][7:0] drv_q;

  ieee_slot_counter #(.IDLE(IDLE), .CW(CW)) u_cnt (
    .clk(clk),
    .reset_n(reset_n),
    .ph2_i(ph2),
    .cnt_o(cnt),
    .overrun_o(overrun)
  );

  // slot decode: which drive reads now, which captures land now, whether the loader owns this slot
  always_comb begin
    rd_sel = '0;
    cap = '0;
    rd_addr = '0;
    for (int i = 0; i < NDR; i++) begin
      rd_sel[i] = (cnt == CW'(i)) && drv_en[i] && !ld_excl;
      cap[i] = pend_q[i] && (cnt == CW'(i + int'(RDLAT)));
      rd_addr = rd_addr | (rd_sel[i] ? drv_addr[i] : '0);
    end
    rd_slot = |rd_sel;
    wr = !rd_slot && ld_req && !ack_q;
    pend_d = ph2 ? '0 : ((pend_q & ~cap) | rd_sel);
  end

  // registered memory port, loader handshake and per-drive capture; ph2 drops in-flight captures
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      ack_q <= 1'b0;
      drv_q <= '0;
    end else begin
      pend_q <= pend_d;
      we_q <= wr;
      ack_q <= wr;
      if (rd_slot) addr_q <= rd_addr;
      else if (wr) begin
        addr_q <= ld_addr;
        data_q <= ld_data;
      end
      for (int i = 0; i < NDR; i++)
        if (cap[i] && !ph2) drv_q[i] <= rom_q;
    end
  end

  assign rom_addr = addr_q;
  assign rom_data = data_q;
  assign rom_we = we_q;
  assign ld_ack = ack_q;
  assign drv_data = drv_q;
endmodule
